fsm_seq_detector: RTL and testbench

- Serial bit-stream pattern detector: samples one input bit per clock and asserts a flag when the most recent bits equal a parameterized pattern.
- Implemented as a Moore FSM whose state is the length of the longest pattern prefix matched so far.
- Used as a leaf block behind any serial data path needing frame, sync or marker detection.

---
 rtl/fsm_seq_detector_pkg.sv | 51 +++++
 rtl/fsm_seq_detector_nxt.sv | 40 ++++
 rtl/fsm_seq_detector.sv | 80 ++++++++
 tb/tb_fsm_seq_detector.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fsm_seq_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsm_seq_detector_pkg
// Description : Shared defaults and elaboration-time helpers for the serial
//               pattern detector (state width, failure-rule next state).
// Revision    : 1.0 - initial release
// ============================================================================
package fsm_seq_detector_pkg;

  localparam int          PAT_LEN_DEF = 4;
  localparam logic [15:0] PATTERN_DEF = 16'h000B;

  function automatic int state_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

  // Longest suffix of (matched prefix, b) that is also a pattern prefix.
  // A full match restarts from the whole pattern (overlap) or from nothing.
  function automatic int next_state(input int          k,
                                    input logic        b,
                                    input logic [15:0] pattern,
                                    input int          pat_len,
                                    input int          overlap);
    logic [16:0] s;
    int          m;
    int          best;
    logic        ok;
    if (k >= pat_len) m = (overlap != 0) ? pat_len : 0;
    else              m = k;
    s = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < m) s[i] = pattern[pat_len-1-i];
    end
    s[m] = b;
    best = 0;
    for (int j = 1; j <= 16; j++) begin
      if (j <= m + 1 && j <= pat_len) begin
        ok = 1'b1;
        for (int t = 0; t < 16; t++) begin
          if (t < j) begin
            if (s[m+1-j+t] != pattern[pat_len-1-t]) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_seq_detector_nxt.sv
`default_nettype none
// ============================================================================
// Module      : fsm_seq_detector_nxt
// Description : Combinational (state, bit) -> next-state lookup whose table is
//               computed at elaboration from the pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_seq_detector_nxt
  import fsm_seq_detector_pkg::*;
#(
  parameter int                 PAT_LEN = PAT_LEN_DEF,
  parameter logic [PAT_LEN-1:0] PATTERN = PATTERN_DEF[PAT_LEN-1:0],
  parameter int                 OVERLAP = 1,
  parameter int                 SW      = state_width(PAT_LEN)
) (
  input  logic [SW-1:0] state,
  input  logic          x,
  output logic [SW-1:0] state_nxt
);

  localparam logic [15:0] PAT16 = 16'(PATTERN);

  logic [SW-1:0] tbl0 [PAT_LEN+1];
  logic [SW-1:0] tbl1 [PAT_LEN+1];

  for (genvar k = 0; k <= PAT_LEN; k++) begin : g_state
    assign tbl0[k] = SW'(next_state(k, 1'b0, PAT16, PAT_LEN, OVERLAP));
    assign tbl1[k] = SW'(next_state(k, 1'b1, PAT16, PAT_LEN, OVERLAP));
  end

  // Unused encodings above S<PAT_LEN> fall back to S0.
  always_comb begin
    state_nxt = '0;
    for (int k = 0; k <= PAT_LEN; k++) begin
      if (state == SW'(k)) state_nxt = x ? tbl1[k] : tbl0[k];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fsm_seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : fsm_seq_detector
// Description : Moore serial pattern detector; state is the matched prefix
//               length. SEQ_DET_CNT_EN adds a saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_seq_detector
  import fsm_seq_detector_pkg::*;
#(
  parameter int                 PAT_LEN = PAT_LEN_DEF,
  parameter logic [PAT_LEN-1:0] PATTERN = PATTERN_DEF[PAT_LEN-1:0],
  parameter int                 OVERLAP = 1,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  output logic             z
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  localparam int SW = state_width(PAT_LEN);

  typedef logic [SW-1:0] state_t;

  localparam state_t S_FULL = SW'(PAT_LEN);

  state_t state;
  state_t state_nxt;
  logic   hit;

  fsm_seq_detector_nxt #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP),
    .SW      (SW)
  ) u_nxt (
    .state     (state),
    .x         (x),
    .state_nxt (state_nxt)
  );

  always_comb begin
    hit = (state_nxt == S_FULL);
  end

  // z is registered alongside state so it equals (state == S_FULL).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= '0;
      z     <= 1'b0;
    end else begin
      state <= state_nxt;
      z     <= hit;
    end
  end

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (hit && (cnt != '1)) cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

  assign match_cnt = cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsm_seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_seq_detector
// Description : Self-checking bench: directed vector table, hand-written corner
//               sequences and random stimulus against a sliding-window model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_seq_detector;

  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x   = 1'b0;
  logic z1, z0, z2;
  logic [CNT_W-1:0] c1, c0, c2;

  always #5 clk = ~clk;

  fsm_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(CNT_W)) u_ov1 (
    .clk(clk), .rst(rst), .x(x), .z(z1)
`ifdef SEQ_DET_CNT_EN
    , .match_cnt(c1)
`endif
  );

  fsm_seq_detector #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(CNT_W)) u_ov0 (
    .clk(clk), .rst(rst), .x(x), .z(z0)
`ifdef SEQ_DET_CNT_EN
    , .match_cnt(c0)
`endif
  );

  fsm_seq_detector #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1), .CNT_W(CNT_W)) u_p11 (
    .clk(clk), .rst(rst), .x(x), .z(z2)
`ifdef SEQ_DET_CNT_EN
    , .match_cnt(c2)
`endif
  );

`ifndef SEQ_DET_CNT_EN
  assign c1 = '0;
  assign c0 = '0;
  assign c2 = '0;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: a match is the last plen bits equalling the pattern,
  // with at least plen bits seen since reset (or since the last hit if no overlap).
  int plen  [3] = '{4, 4, 2};
  int pat   [3] = '{11, 11, 3};
  int ovl   [3] = '{1, 0, 1};
  int win   [3];
  int since [3];
  int mcnt  [3];
  int mz    [3];

  task automatic model_step(input logic r, input logic b);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        win[i] = 0; since[i] = 0; mcnt[i] = 0; mz[i] = 0;
      end else begin
        win[i]   = (win[i] * 2 + int'(b)) % (1 << plen[i]);
        since[i] = since[i] + 1;
        mz[i]    = 0;
        if (since[i] >= plen[i] && win[i] == pat[i]) begin
          mz[i] = 1;
          if (mcnt[i] < (1 << CNT_W) - 1) mcnt[i] = mcnt[i] + 1;
          if (ovl[i] == 0) since[i] = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic b);
    @(negedge clk);
    rst = r;
    x   = b;
    model_step(r, b);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic r;
    logic b;
    logic ez1;
    logic ez0;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic b, input logic ez1, input logic ez0);
    vec_t v;
    v.r = r; v.b = b; v.ez1 = ez1; v.ez0 = ez0;
    vecs.push_back(v);
  endtask

  initial begin
    // Reset, then zeros.
    add(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0);
    // Basic match 1,0,1,1,1,0,0,1,1,1.
    add(1, 0, 0, 0);
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 1, 1, 1);
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0);
    add(0, 1, 0, 0); add(0, 1, 0, 0);
    // Overlap 1,0,1,1,0,1,1.
    add(1, 0, 0, 0);
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 1, 1, 1);
    add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 1, 1, 0);
    // Failure fallback 1,0,1,0,1,1.
    add(1, 0, 0, 0);
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 0);
    add(0, 1, 0, 0); add(0, 1, 1, 1);
    // Reset mid-pattern with x=1 during reset, then 1,0,1,1.
    add(1, 0, 0, 0);
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(1, 1, 0, 0);
    add(0, 1, 0, 0); add(0, 0, 0, 0); add(0, 1, 0, 0); add(0, 1, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].b);
      check($sformatf("vec%0d_z_ov1", i), int'(z1), int'(vecs[i].ez1));
      check($sformatf("vec%0d_z_ov0", i), int'(z0), int'(vecs[i].ez0));
`ifdef SEQ_DET_CNT_EN
      if (i < 6) check($sformatf("vec%0d_cnt_reset", i), int'(c1), 0);
      if (i == 10) check("basic_cnt", int'(c1), 1);
`endif
    end

    // PATTERN=11 with overlap: input 1,1,1 gives a two-cycle z level.
    step(1, 0);
    step(0, 1); check("p11_bit1", int'(z2), 0);
    step(0, 1); check("p11_bit2", int'(z2), 1);
    step(0, 1); check("p11_bit3", int'(z2), 1);
    step(0, 0); check("p11_bit4", int'(z2), 0);

`ifdef SEQ_DET_CNT_EN
    // Five overlapping hits with a 2-bit counter: 1,2,3,3,3.
    begin
      logic [15:0] sat_seq;
      int          exp_cnt;
      sat_seq = 16'b1011011011011011;
      exp_cnt = 0;
      step(1, 0);
      for (int i = 15; i >= 0; i--) begin
        step(0, sat_seq[i]);
        if ((15 - i) % 3 == 0 && i != 15) begin
          if (exp_cnt < 3) exp_cnt++;
          check($sformatf("sat_cnt_bit%0d", 16 - i), int'(c1), exp_cnt);
        end
      end
    end
`endif

    // Random stream with occasional resets, against the window model.
    step(1, 0);
    for (int n = 0; n < 600; n++) begin
      logic r;
      logic b;
      r = ($urandom_range(0, 39) == 0);
      b = ($urandom_range(0, 3) != 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      step(r, b);
      check("rnd_z_ov1", int'(z1), mz[0]);
      check("rnd_z_ov0", int'(z0), mz[1]);
      check("rnd_z_p11", int'(z2), mz[2]);
`ifdef SEQ_DET_CNT_EN
      check("rnd_cnt_ov1", int'(c1), mcnt[0]);
      check("rnd_cnt_ov0", int'(c0), mcnt[1]);
      check("rnd_cnt_p11", int'(c2), mcnt[2]);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
